// File: rtl/spm_mem_responder_if.sv
// SPM memory responder bundle: datapath strobes, host init port and status flags.
// Define MEM_PARITY_EN to add init_par_inv and parity_err.
// Master drives requests; slave reports mem_ready (low = requests ignored).
interface spm_mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              load_addr;
    logic              write;
    logic [DATA_W-1:0] bus_1;
    logic [DATA_W-1:0] mem_word;
    logic              mem_ready;
    logic              init_en;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    logic              addr_err;
    logic              proto_err;
`ifdef MEM_PARITY_EN
    logic              init_par_inv;
    logic              parity_err;
`endif

    modport master (
        output load_addr, write, bus_1, init_en, init_we, init_addr, init_data,
`ifdef MEM_PARITY_EN
        output init_par_inv,
        input  parity_err,
`endif
        input  mem_word, mem_ready, addr_err, proto_err
    );

    modport slave (
        input  load_addr, write, bus_1, init_en, init_we, init_addr, init_data,
`ifdef MEM_PARITY_EN
        input  init_par_inv,
        output parity_err,
`endif
        output mem_word, mem_ready, addr_err, proto_err
    );
endinterface

// File: rtl/spm_mem_responder.sv
// SPM bus memory responder with wait states and host init port; MEM_PARITY_EN adds per-word parity.
// Latency: mem_word follows addr_reg combinationally, so new address/data is visible one cycle after the edge.
// Backpressure: mem_ready low for WAIT_CYCLES after each request and throughout INIT; strobes then are dropped and flagged.
module spm_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    spm_mem_responder_if.slave  bus
);
    localparam int       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit       HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        INIT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_reg, addr_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               addr_err_q, addr_err_nxt;
    logic               proto_err_q, proto_err_nxt;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic               wr_en;
    logic               wr_go;
    logic               wr_from_init;
    logic [IDX_W-1:0]   wr_idx;
    logic [DATA_W-1:0]  wr_dat;
    logic [IDX_W-1:0]   rd_idx;
    logic [DATA_W-1:0]  rd_word;
    logic [ADDR_W-1:0]  bus_addr;
    logic               bus_req;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    // Address register takes the low ADDR_W bits of the data bus.
    assign bus_addr = ADDR_W'(bus.bus_1);
    assign bus_req  = bus.load_addr | bus.write;

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr_reg;
        cnt_nxt       = cnt;
        addr_err_nxt  = addr_err_q;
        proto_err_nxt = proto_err_q;
        wr_en         = 1'b0;
        wr_from_init  = 1'b0;
        wr_idx        = to_idx(addr_reg);
        wr_dat        = bus.bus_1;

        unique case (state)
            IDLE: begin
                if (bus.load_addr) begin
                    // A simultaneous write is suppressed; the address still loads.
                    addr_nxt = bus_addr;
                    if (!in_range(bus_addr)) addr_err_nxt = 1'b1;
                    if (bus.write)           proto_err_nxt = 1'b1;
                    if (HAS_WAIT) begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_LD;
                    end
                end else if (bus.write) begin
                    if (in_range(addr_reg)) wr_en        = 1'b1;
                    else                    addr_err_nxt = 1'b1;
                    if (HAS_WAIT) begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_LD;
                    end
                end else if (bus.init_en) begin
                    state_nxt = INIT;
                end
            end

            WAIT: begin
                if (bus_req) proto_err_nxt = 1'b1;
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            end

            INIT: begin
                if (bus_req) proto_err_nxt = 1'b1;
                wr_idx       = to_idx(bus.init_addr);
                wr_dat       = bus.init_data;
                wr_from_init = 1'b1;
                if (bus.init_we) begin
                    if (in_range(bus.init_addr)) wr_en        = 1'b1;
                    else                         addr_err_nxt = 1'b1;
                end
                if (!bus.init_en) state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_reg    <= '0;
            cnt         <= 4'd0;
            addr_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            addr_reg    <= addr_nxt;
            cnt         <= cnt_nxt;
            addr_err_q  <= addr_err_nxt;
            proto_err_q <= proto_err_nxt;
        end
    end

    // Storage has no reset; a clock edge seen while rst is held must not commit.
    assign wr_go = wr_en & ~rst;

    always_ff @(posedge clk) begin
        if (wr_go) mem[wr_idx] <= wr_dat;
    end

    assign rd_idx        = to_idx(addr_reg);
    assign rd_word       = mem[rd_idx];
    assign bus.mem_word  = in_range(addr_reg) ? rd_word : '0;
    assign bus.mem_ready = (state == IDLE);
    assign bus.addr_err  = addr_err_q;
    assign bus.proto_err = proto_err_q;

`ifdef MEM_PARITY_EN
    logic par_mem [DEPTH];
    logic wr_par;

    // Even parity; host may invert it on init writes to plant a fault.
    assign wr_par = (^wr_dat) ^ (wr_from_init & bus.init_par_inv);

    always_ff @(posedge clk) begin
        if (wr_go) par_mem[wr_idx] <= wr_par;
    end

    assign bus.parity_err = bus.mem_ready & in_range(addr_reg) &
                            ((^rd_word) != par_mem[rd_idx]);
`else
    logic unused_init_sel;
    assign unused_init_sel = wr_from_init;
`endif

endmodule

// File: tb/tb_spm_mem_responder.sv
// Drives two responders (DEPTH 256/no wait, DEPTH 128/3 waits) with shared stimulus,
// checking both against a per-instance reference model plus directed constant expectations.
module tb_spm_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       load_addr = 1'b0;
    logic       write     = 1'b0;
    logic [7:0] bus_1     = 8'h00;
    logic       init_en   = 1'b0;
    logic       init_we   = 1'b0;
    logic [7:0] init_addr = 8'h00;
    logic [7:0] init_data = 8'h00;
    logic       init_par_inv = 1'b0;

    spm_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) if0 ();
    spm_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) if1 ();

    assign if0.load_addr = load_addr;  assign if1.load_addr = load_addr;
    assign if0.write     = write;      assign if1.write     = write;
    assign if0.bus_1     = bus_1;      assign if1.bus_1     = bus_1;
    assign if0.init_en   = init_en;    assign if1.init_en   = init_en;
    assign if0.init_we   = init_we;    assign if1.init_we   = init_we;
    assign if0.init_addr = init_addr;  assign if1.init_addr = init_addr;
    assign if0.init_data = init_data;  assign if1.init_data = init_data;

    logic [7:0] o_word  [2];
    logic       o_ready [2];
    logic       o_aerr  [2];
    logic       o_perr  [2];
    logic       o_par   [2];
    assign o_word[0]  = if0.mem_word;   assign o_word[1]  = if1.mem_word;
    assign o_ready[0] = if0.mem_ready;  assign o_ready[1] = if1.mem_ready;
    assign o_aerr[0]  = if0.addr_err;   assign o_aerr[1]  = if1.addr_err;
    assign o_perr[0]  = if0.proto_err;  assign o_perr[1]  = if1.proto_err;
`ifdef MEM_PARITY_EN
    assign if0.init_par_inv = init_par_inv;  assign if1.init_par_inv = init_par_inv;
    assign o_par[0] = if0.parity_err;   assign o_par[1] = if1.parity_err;
`else
    assign o_par[0] = 1'b0;             assign o_par[1] = 1'b0;
`endif

    spm_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    spm_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(3))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    // Reference model: per instance, address, remaining stall cycles, init mode, flags, memory image.
    int         m_depth [2] = '{256, 128};
    int         m_wait  [2] = '{0, 3};
    logic [7:0] m_addr  [2];
    int         m_stall [2];
    bit         m_init  [2];
    bit         m_aerr  [2];
    bit         m_perr  [2];
    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];
    bit         m_pbad  [2][256];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = 8'h00; m_stall[k] = 0; m_init[k] = 1'b0;
            m_aerr[k] = 1'b0;  m_perr[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!m_init[k] && m_stall[k] == 0) begin
                if (load_addr) begin
                    m_addr[k] = bus_1;
                    if (int'(bus_1) >= m_depth[k]) m_aerr[k] = 1'b1;
                    if (write) m_perr[k] = 1'b1;
                    m_stall[k] = m_wait[k];
                end else if (write) begin
                    if (int'(m_addr[k]) < m_depth[k]) begin
                        m_mem[k][m_addr[k]] = bus_1;
                        m_known[k][m_addr[k]] = 1'b1;
                        m_pbad[k][m_addr[k]] = 1'b0;
                    end else m_aerr[k] = 1'b1;
                    m_stall[k] = m_wait[k];
                end else if (init_en) m_init[k] = 1'b1;
            end else if (m_stall[k] > 0) begin
                if (load_addr || write) m_perr[k] = 1'b1;
                m_stall[k]--;
            end else begin
                if (load_addr || write) m_perr[k] = 1'b1;
                if (init_we) begin
                    if (int'(init_addr) < m_depth[k]) begin
                        m_mem[k][init_addr] = init_data;
                        m_known[k][init_addr] = 1'b1;
                        m_pbad[k][init_addr] = init_par_inv;
                    end else m_aerr[k] = 1'b1;
                end
                if (!init_en) m_init[k] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            bit rdy, inr;
            rdy = !m_init[k] && (m_stall[k] == 0);
            inr = int'(m_addr[k]) < m_depth[k];
            chk($sformatf("mem_ready[%0d]", k), 32'(o_ready[k]), 32'(rdy));
            chk($sformatf("addr_err[%0d]", k),  32'(o_aerr[k]),  32'(m_aerr[k]));
            chk($sformatf("proto_err[%0d]", k), 32'(o_perr[k]),  32'(m_perr[k]));
            if (!inr)
                chk($sformatf("mem_word_oor[%0d]", k), 32'(o_word[k]), 32'h0);
            else if (m_known[k][m_addr[k]]) begin
                chk($sformatf("mem_word[%0d]", k), 32'(o_word[k]), 32'(m_mem[k][m_addr[k]]));
`ifdef MEM_PARITY_EN
                chk($sformatf("parity_err[%0d]", k), 32'(o_par[k]),
                    32'(rdy && m_pbad[k][m_addr[k]]));
`endif
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        load_addr = 1'b0; write = 1'b0; init_we = 1'b0; init_par_inv = 1'b0;
    endtask

    task automatic gap(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_load(input logic [7:0] a);
        idle(); load_addr = 1'b1; bus_1 = a; tick(); idle();
    endtask

    task automatic bus_write(input logic [7:0] d);
        idle(); write = 1'b1; bus_1 = d; tick(); idle();
    endtask

    task automatic do_reset();
        idle(); init_en = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        model_reset();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++) begin
                m_known[k][a] = 1'b0; m_pbad[k][a] = 1'b0; m_mem[k][a] = 8'h00;
            end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ready[%0d]", k), 32'(o_ready[k]), 32'h1);
            chk($sformatf("rst_aerr[%0d]", k),  32'(o_aerr[k]),  32'h0);
            chk($sformatf("rst_perr[%0d]", k),  32'(o_perr[k]),  32'h0);
        end
        rst = 1'b0;

        // Host init of words 0..127 (in range for both instances).
        init_en = 1'b1;
        tick();
        chk("init_ready0", 32'(o_ready[0]), 32'h0);
        init_we = 1'b1;
        for (int a = 0; a < 128; a++) begin
            init_addr = 8'(a);
            init_data = (a == 0) ? 8'h15 : (a == 1) ? 8'h2A : 8'($urandom);
            tick();
        end
        init_we = 1'b0; init_en = 1'b0;
        tick();
        chk("init_exit_ready1", 32'(o_ready[1]), 32'h1);

        // Fetch-style reads; instance 1 stalls exactly three cycles.
        bus_load(8'h00);
        chk("rd0_w0", 32'(o_word[0]), 32'h15);
        chk("rd0_w1", 32'(o_word[1]), 32'h15);
        chk("stall_c1", 32'(o_ready[1]), 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_cn", 32'(o_ready[1]), 32'h0);
        end
        tick();
        chk("stall_end", 32'(o_ready[1]), 32'h1);
        bus_load(8'h01);
        chk("rd1_w0", 32'(o_word[0]), 32'h2A);
        chk("rd1_w1", 32'(o_word[1]), 32'h2A);
        gap(3);

        // Write-through visibility.
        bus_load(8'h40); gap(3);
        bus_write(8'hC3);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wr_word[%0d]", k), 32'(o_word[k]), 32'hC3);
            chk($sformatf("wr_aerr[%0d]", k), 32'(o_aerr[k]), 32'h0);
            chk($sformatf("wr_perr[%0d]", k), 32'(o_perr[k]), 32'h0);
        end
        gap(3);

        // Write during stall: instance 1 drops it and flags a protocol error.
        bus_load(8'h10);
        bus_write(8'h99);
        chk("stallwr_perr1", 32'(o_perr[1]), 32'h1);
        chk("stallwr_perr0", 32'(o_perr[0]), 32'h0);
        chk("stallwr_word0", 32'(o_word[0]), 32'h99);
        gap(3);

        // Out-of-range address on the DEPTH=128 instance.
        do_reset();
        bus_load(8'h90);
        chk("oor_word1", 32'(o_word[1]), 32'h0);
        chk("oor_aerr1", 32'(o_aerr[1]), 32'h1);
        chk("oor_aerr0", 32'(o_aerr[0]), 32'h0);
        gap(3);
        bus_write(8'h77);
        gap(3);
        bus_load(8'h10);
        gap(3);
        bus_load(8'h90);
        chk("oor_wr_word0", 32'(o_word[0]), 32'h77);
        gap(3);

        // Load and write together.
        do_reset();
        idle(); load_addr = 1'b1; write = 1'b1; bus_1 = 8'h05; tick(); idle();
        chk("both_perr0", 32'(o_perr[0]), 32'h1);
        chk("both_perr1", 32'(o_perr[1]), 32'h1);
        gap(3);

        // Reset asserted mid-INIT; the committed init write survives.
        init_en = 1'b1; tick();
        init_we = 1'b1; init_addr = 8'h03; init_data = 8'hA5; tick();
        init_we = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        init_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("arst_ready[%0d]", k), 32'(o_ready[k]), 32'h1);
            chk($sformatf("arst_aerr[%0d]", k),  32'(o_aerr[k]),  32'h0);
            chk($sformatf("arst_perr[%0d]", k),  32'(o_perr[k]),  32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        bus_load(8'h03);
        chk("arst_keep0", 32'(o_word[0]), 32'hA5);
        chk("arst_keep1", 32'(o_word[1]), 32'hA5);
        gap(3);

        // Randomised traffic checked every cycle against the model.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 11);
            load_addr = (r < 3);
            write     = (r >= 2 && r < 5);
            bus_1     = 8'($urandom);
            if ($urandom_range(0, 9) == 0) init_en = ~init_en;
            init_we      = 1'($urandom_range(0, 1));
            init_addr    = 8'($urandom);
            init_data    = 8'($urandom);
            init_par_inv = 1'($urandom_range(0, 1));
            tick();
        end
        init_en = 1'b0;
        gap(4);

`ifdef MEM_PARITY_EN
        // Planted parity fault, then repaired by a bus write.
        do_reset();
        init_en = 1'b1; tick();
        init_we = 1'b1; init_addr = 8'h02; init_data = 8'h03; init_par_inv = 1'b1; tick();
        init_we = 1'b0; init_par_inv = 1'b0; init_en = 1'b0; tick();
        bus_load(8'h02); gap(3);
        chk("par_bad0", 32'(o_par[0]), 32'h1);
        chk("par_bad1", 32'(o_par[1]), 32'h1);
        bus_write(8'h03); gap(3);
        chk("par_ok0", 32'(o_par[0]), 32'h0);
        chk("par_ok1", 32'(o_par[1]), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spm_mem_responder.md
Name: spm_mem_responder

Overview:
- Memory-side responder for the SPM CPU bus: captures addresses from bus_1 on load_addr, performs writes on the write strobe, and presents the addressed word on mem_word for bus_2.
- Adds configurable wait states reported on mem_ready, and a host init port for loading programs before or between runs.
- Sits between the controller/datapath and program/data storage; replaces ad-hoc bench memory models.

Parameters:
- ADDR_W, 8, width of the address register and bus_1.
- DATA_W, 8, word width.
- DEPTH, 256, number of implemented words; must be at most 2**ADDR_W.
- WAIT_CYCLES, 0, stall cycles after each load_addr or write; range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- load_addr  in  1  capture bus_1 into the address register.
- write  in  1  store bus_1 into mem[addr_reg].
- bus_1  in  DATA_W  address or write data from the datapath.
- mem_word  out  DATA_W  mem[addr_reg]; combinational from addr_reg; 0 if addr_reg >= DEPTH.
- mem_ready  out  1  high when the responder accepts a new request.
- init_en  in  1  host init mode request.
- init_we  in  1  init write strobe.
- init_addr  in  ADDR_W  init write address.
- init_data  in  DATA_W  init write data.
- addr_err  out  1  sticky flag: out-of-range access.
- proto_err  out  1  sticky flag: protocol violation.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, addr_reg=0, wait counter=0.
  - mem_ready=1, addr_err=0, proto_err=0.
  - Memory array is not cleared.
  - Reset mid-WAIT or mid-INIT aborts immediately; any write already committed persists.
- IDLE (mem_ready=1):
  - load_addr: addr_reg<=bus_1. If WAIT_CYCLES>0, go to WAIT with cnt=WAIT_CYCLES.
  - write (load_addr=0): mem[addr_reg]<=bus_1 on the same edge. If WAIT_CYCLES>0, go to WAIT.
  - load_addr and write together: address loads, write is suppressed, proto_err<=1.
  - init_en=1 with no bus request: go to INIT. If a bus request occurs in the same cycle, the bus request wins and INIT is entered on the first later idle cycle with init_en still high.
- WAIT (mem_ready=0):
  - cnt decrements each cycle; cnt==1 returns to IDLE on the next edge.
  - Total stall = WAIT_CYCLES cycles of mem_ready=0.
  - load_addr or write in WAIT: ignored, proto_err<=1.
  - mem_word stays valid for the current addr_reg throughout.
- INIT (mem_ready=0):
  - init_we=1: mem[init_addr]<=init_data, one word per cycle.
  - init_en=0: return to IDLE on the next edge.
  - Bus strobes in INIT: ignored, proto_err<=1.
- Latency:
  - With WAIT_CYCLES=0, mem_word reflects the new address in the cycle after the load_addr edge. This matches the fetch sequence of address load followed by IR load.
  - Write data is visible on mem_word in the cycle after the write edge when addr_reg is unchanged.
- Out of range (addr_reg or init_addr >= DEPTH):
  - Read returns 0; write is dropped; addr_err<=1.
  - The address itself still loads.
- Sticky flags: addr_err and proto_err clear only on reset.
- Width rule: addr_reg takes the low ADDR_W bits of bus_1.

Optional Feature:
MEM_PARITY_EN
- Defined:
  - Each word stores an even-parity bit computed on write (bus or init).
  - Adds input init_par_inv: when high during an init write, the stored parity bit is inverted, for fault injection.
  - Adds output parity_err: combinational, high when the parity of mem[addr_reg] mismatches, gated by mem_ready=1.
- Undefined: no parity storage, no init_par_inv or parity_err ports. Behaviour is otherwise identical.

Test Plan:
- Reset, then init writes mem[0]=8'h15 and mem[1]=8'h2A, then init_en=0; load_addr with bus_1=0 -> mem_word=8'h15 the next cycle. load_addr with bus_1=1 -> 8'h2A.
- load_addr bus_1=8'h40, then write bus_1=8'hC3 -> next cycle mem_word=8'hC3, addr_err=0, proto_err=0.
- WAIT_CYCLES=3: load_addr -> mem_ready low for exactly 3 cycles then high. A write issued during the stall leaves memory unchanged and sets proto_err=1.
- DEPTH=128: load_addr bus_1=8'h90 -> mem_word=0, addr_err=1. A following write of 8'h77 is dropped, and mem[8'h10] is unchanged.
- load_addr and write asserted together with bus_1=8'h05 -> addr_reg=5, memory unchanged, proto_err=1. Assert rst mid-INIT -> state IDLE, mem_ready=1, flags 0.
- MEM_PARITY_EN: init write 8'h03 with init_par_inv=1 to address 2, then load_addr 2 -> parity_err=1. Overwrite via bus write 8'h03 -> parity_err=0.
